// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_ctrl_if
//  Description : Bundle of byte-handshake and command-strobe signals between
//                the UART receiver, the command controller and the register
//                file / ADC capture logic.
//                master : controller side (drives clr, strobes, status)
//                slave  : environment side (drives rx_data / rx_rdy)
//  Signals     : uart_cmd_rx_data[7:0], uart_cmd_rx_rdy, uart_cmd_rx_clr,
//                uart_cmd_cfg_we, uart_cmd_cfg_addr[7:0],
//                uart_cmd_cfg_data[7:0], uart_cmd_cap_start,
//                uart_cmd_cap_stop, uart_cmd_err, uart_cmd_err_cnt[7:0],
//                uart_cmd_busy
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_ctrl_if;
    logic [7:0] uart_cmd_rx_data;
    logic       uart_cmd_rx_rdy;
    logic       uart_cmd_rx_clr;
    logic       uart_cmd_cfg_we;
    logic [7:0] uart_cmd_cfg_addr;
    logic [7:0] uart_cmd_cfg_data;
    logic       uart_cmd_cap_start;
    logic       uart_cmd_cap_stop;
    logic       uart_cmd_err;
    logic [7:0] uart_cmd_err_cnt;
    logic       uart_cmd_busy;

    modport master (
        input  uart_cmd_rx_data, uart_cmd_rx_rdy,
        output uart_cmd_rx_clr, uart_cmd_cfg_we, uart_cmd_cfg_addr,
               uart_cmd_cfg_data, uart_cmd_cap_start, uart_cmd_cap_stop,
               uart_cmd_err, uart_cmd_err_cnt, uart_cmd_busy
    );

    modport slave (
        output uart_cmd_rx_data, uart_cmd_rx_rdy,
        input  uart_cmd_rx_clr, uart_cmd_cfg_we, uart_cmd_cfg_addr,
               uart_cmd_cfg_data, uart_cmd_cap_start, uart_cmd_cap_stop,
               uart_cmd_err, uart_cmd_err_cnt, uart_cmd_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_ctrl
//  Description : UART command decoder. Takes bytes from the receiver through
//                a rdy/clr handshake, assembles 5-byte frames
//                (A5, CMD, ADDR, DATA, CSUM = CMD^ADDR^DATA) and issues
//                register-write / capture-start / capture-stop strobes.
//                Bad commands and checksum mismatches pulse err and bump a
//                saturating error counter.
//  Ports       : uart_cmd_bclk   - bit clock shared with the receiver
//                uart_cmd_rst_n  - asynchronous active-low reset
//                uart_cmd_bus    - uart_cmd_ctrl_if.master (handshake,
//                                  strobes, status)
//  Parameters  : TIMEOUT_CYC     - inter-byte timeout in bclk cycles (16..65535)
//  Macros      : UART_CMD_TIMEOUT_EN - when defined, a partial frame that
//                sees no byte for TIMEOUT_CYC cycles is dropped with err.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic          uart_cmd_bclk,
    input  wire logic          uart_cmd_rst_n,
    uart_cmd_ctrl_if.master    uart_cmd_bus
);

    localparam logic [7:0] c_SYNC     = 8'hA5;
    localparam logic [7:0] c_CMD_WR   = 8'h01;
    localparam logic [7:0] c_CMD_STRT = 8'h02;
    localparam logic [7:0] c_CMD_STOP = 8'h03;

    if (TIMEOUT_CYC < 16 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("uart_cmd_ctrl: TIMEOUT_CYC out of range 16..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_EXEC = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_rx_clr;
    logic       w_accept;
    logic [7:0] r_cmd;
    logic [7:0] r_adr;
    logic [7:0] r_dat;
    logic       r_cfg_we;
    logic [7:0] r_cfg_addr;
    logic [7:0] r_cfg_data;
    logic       r_cap_start;
    logic       r_cap_stop;
    logic       r_err;
    logic [7:0] r_err_cnt;
    logic       w_cfg_we_nxt;
    logic       w_cap_start_nxt;
    logic       w_cap_stop_nxt;
    logic       w_err_nxt;
    logic       w_cmd_ok;
    logic       w_timeout;

    // A byte is taken only while clr is low; clr simply mirrors rdy one edge
    // later, which both raises it after a take and holds it until rdy drops.
    assign w_accept = uart_cmd_bus.uart_cmd_rx_rdy & ~r_rx_clr;
    assign w_cmd_ok = (uart_cmd_bus.uart_cmd_rx_data == c_CMD_WR)   ||
                      (uart_cmd_bus.uart_cmd_rx_data == c_CMD_STRT) ||
                      (uart_cmd_bus.uart_cmd_rx_data == c_CMD_STOP);

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] r_to_cnt;

    // A byte arriving in the limit cycle wins over the timeout.
    assign w_timeout = (r_state != ST_IDLE) && (r_state != ST_EXEC) &&
                       !w_accept && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge uart_cmd_bclk or negedge uart_cmd_rst_n) begin
        if (!uart_cmd_rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_IDLE || w_accept) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cfg_we_nxt    = 1'b0;
        w_cap_start_nxt = 1'b0;
        w_cap_stop_nxt  = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && uart_cmd_bus.uart_cmd_rx_data == c_SYNC)
                    w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (w_accept) begin
                    if (w_cmd_ok) begin
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (w_accept) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_accept) w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_accept) begin
                    if (uart_cmd_bus.uart_cmd_rx_data == (r_cmd ^ r_adr ^ r_dat)) begin
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                // Strobes register on the edge leaving EXEC, one cycle after
                // the checksum byte was taken.
                w_state_nxt     = ST_IDLE;
                w_cfg_we_nxt    = (r_cmd == c_CMD_WR);
                w_cap_start_nxt = (r_cmd == c_CMD_STRT);
                w_cap_stop_nxt  = (r_cmd == c_CMD_STOP);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge uart_cmd_bclk or negedge uart_cmd_rst_n) begin
        if (!uart_cmd_rst_n) begin
            r_state     <= ST_IDLE;
            r_rx_clr    <= 1'b0;
            r_cmd       <= 8'h00;
            r_adr       <= 8'h00;
            r_dat       <= 8'h00;
            r_cfg_we    <= 1'b0;
            r_cfg_addr  <= 8'h00;
            r_cfg_data  <= 8'h00;
            r_cap_start <= 1'b0;
            r_cap_stop  <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_clr    <= uart_cmd_bus.uart_cmd_rx_rdy;
            r_cfg_we    <= w_cfg_we_nxt;
            r_cap_start <= w_cap_start_nxt;
            r_cap_stop  <= w_cap_stop_nxt;
            r_err       <= w_err_nxt;
            if (w_accept) begin
                case (r_state)
                    ST_CMD:  r_cmd <= uart_cmd_bus.uart_cmd_rx_data;
                    ST_ADDR: r_adr <= uart_cmd_bus.uart_cmd_rx_data;
                    ST_DATA: r_dat <= uart_cmd_bus.uart_cmd_rx_data;
                    default: ;
                endcase
            end
            if (w_cfg_we_nxt) begin
                r_cfg_addr <= r_adr;
                r_cfg_data <= r_dat;
            end
            if (w_err_nxt && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign uart_cmd_bus.uart_cmd_rx_clr    = r_rx_clr;
    assign uart_cmd_bus.uart_cmd_cfg_we    = r_cfg_we;
    assign uart_cmd_bus.uart_cmd_cfg_addr  = r_cfg_addr;
    assign uart_cmd_bus.uart_cmd_cfg_data  = r_cfg_data;
    assign uart_cmd_bus.uart_cmd_cap_start = r_cap_start;
    assign uart_cmd_bus.uart_cmd_cap_stop  = r_cap_stop;
    assign uart_cmd_bus.uart_cmd_err       = r_err;
    assign uart_cmd_bus.uart_cmd_err_cnt   = r_err_cnt;
    assign uart_cmd_bus.uart_cmd_busy      = (r_state != ST_IDLE);

    // EXEC is entered on the edge that raised clr, so the handshake keeps
    // any new byte out of that cycle.
    a_no_byte_in_exec: assert property (
        @(posedge uart_cmd_bclk) disable iff (!uart_cmd_rst_n)
        !(r_state == ST_EXEC && w_accept)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_ctrl
//  Description : Directed self-checking bench for uart_cmd_ctrl. Bytes are
//                fed through the rdy/clr handshake; strobe pulses are
//                counted on the falling clock edge and compared against
//                hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(.TIMEOUT_CYC(64)) u_dut (
        .uart_cmd_bclk  (clk),
        .uart_cmd_rst_n (rst_n),
        .uart_cmd_bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int we_seen, start_seen, stop_seen, err_seen;
    logic [7:0] we_addr, we_data;

    always @(negedge clk) begin
        if (bus.uart_cmd_cfg_we) begin
            we_seen++;
            we_addr = bus.uart_cmd_cfg_addr;
            we_data = bus.uart_cmd_cfg_data;
        end
        if (bus.uart_cmd_cap_start) start_seen++;
        if (bus.uart_cmd_cap_stop)  stop_seen++;
        if (bus.uart_cmd_err)       err_seen++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        we_seen = 0; start_seen = 0; stop_seen = 0; err_seen = 0;
        we_addr = 8'h00; we_data = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Receiver model: present the byte, expect clr one edge later, keep rdy
    // for 'hold' extra cycles, then drop rdy and expect clr to follow.
    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        bus.uart_cmd_rx_data = b;
        bus.uart_cmd_rx_rdy  = 1'b1;
        @(negedge clk);
        check_val("clr_rise", 32'(bus.uart_cmd_rx_clr), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("clr_hold", 32'(bus.uart_cmd_rx_clr), 32'd1);
        end
        bus.uart_cmd_rx_rdy = 1'b0;
        @(negedge clk);
        check_val("clr_fall", 32'(bus.uart_cmd_rx_clr), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] s);
        send_byte(8'hA5, 0);
        send_byte(c, 0);
        send_byte(a, 0);
        send_byte(d, 0);
        send_byte(s, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_clr"},   32'(bus.uart_cmd_rx_clr),    32'd0);
        check_val({tag, "_we"},    32'(bus.uart_cmd_cfg_we),    32'd0);
        check_val({tag, "_start"}, 32'(bus.uart_cmd_cap_start), 32'd0);
        check_val({tag, "_stop"},  32'(bus.uart_cmd_cap_stop),  32'd0);
        check_val({tag, "_err"},   32'(bus.uart_cmd_err),       32'd0);
        check_val({tag, "_busy"},  32'(bus.uart_cmd_busy),      32'd0);
        check_val({tag, "_addr"},  32'(bus.uart_cmd_cfg_addr),  32'd0);
        check_val({tag, "_data"},  32'(bus.uart_cmd_cfg_data),  32'd0);
        check_val({tag, "_ecnt"},  32'(bus.uart_cmd_err_cnt),   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.uart_cmd_rx_data = 8'h00;
        bus.uart_cmd_rx_rdy  = 1'b0;
        clear_seen();
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Register write frame
        clear_seen();
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        idle(3);
        check_val("wr_count", 32'(we_seen), 32'd1);
        check_val("wr_addr",  32'(we_addr), 32'h10);
        check_val("wr_data",  32'(we_data), 32'h3C);
        check_val("wr_ecnt",  32'(bus.uart_cmd_err_cnt), 32'd0);
        check_val("wr_err",   32'(err_seen), 32'd0);
        check_val("wr_busy",  32'(bus.uart_cmd_busy), 32'd0);

        // Capture start then stop
        clear_seen();
        send_frame(8'h02, 8'h00, 8'h00, 8'h02);
        idle(3);
        check_val("start_count", 32'(start_seen), 32'd1);
        check_val("start_nostop", 32'(stop_seen), 32'd0);
        check_val("start_nowe", 32'(we_seen), 32'd0);
        send_frame(8'h03, 8'h00, 8'h00, 8'h03);
        idle(3);
        check_val("stop_count", 32'(stop_seen), 32'd1);
        check_val("stop_start", 32'(start_seen), 32'd1);
        check_val("addr_hold", 32'(bus.uart_cmd_cfg_addr), 32'h10);
        check_val("data_hold", 32'(bus.uart_cmd_cfg_data), 32'h3C);

        // Bad checksum, then a good frame
        clear_seen();
        send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
        idle(3);
        check_val("csum_err", 32'(err_seen), 32'd1);
        check_val("csum_nowe", 32'(we_seen), 32'd0);
        check_val("csum_ecnt", 32'(bus.uart_cmd_err_cnt), 32'd1);
        check_val("csum_busy", 32'(bus.uart_cmd_busy), 32'd0);
        send_frame(8'h01, 8'h22, 8'h33, 8'h10);
        idle(3);
        check_val("after_we", 32'(we_seen), 32'd1);
        check_val("after_addr", 32'(bus.uart_cmd_cfg_addr), 32'h22);
        check_val("after_data", 32'(bus.uart_cmd_cfg_data), 32'h33);
        check_val("after_ecnt", 32'(bus.uart_cmd_err_cnt), 32'd1);

        // Sync hunting and bad command
        clear_seen();
        send_byte(8'h00, 2);
        send_byte(8'hFF, 1);
        check_val("hunt_busy", 32'(bus.uart_cmd_busy), 32'd0);
        check_val("hunt_err", 32'(err_seen), 32'd0);
        send_byte(8'hA5, 0);
        check_val("sync_busy", 32'(bus.uart_cmd_busy), 32'd1);
        send_byte(8'h07, 1);
        idle(2);
        check_val("badcmd_err", 32'(err_seen), 32'd1);
        check_val("badcmd_busy", 32'(bus.uart_cmd_busy), 32'd0);
        check_val("badcmd_ecnt", 32'(bus.uart_cmd_err_cnt), 32'd2);

        // Partial frame followed by silence
        clear_seen();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        idle(70);
`ifdef UART_CMD_TIMEOUT_EN
        check_val("to_err", 32'(err_seen), 32'd1);
        check_val("to_busy", 32'(bus.uart_cmd_busy), 32'd0);
        check_val("to_ecnt", 32'(bus.uart_cmd_err_cnt), 32'd3);
`else
        check_val("to_err", 32'(err_seen), 32'd0);
        check_val("to_busy", 32'(bus.uart_cmd_busy), 32'd1);
        check_val("to_ecnt", 32'(bus.uart_cmd_err_cnt), 32'd2);
`endif

        // Reset in the middle of a frame
        send_byte(8'hA5, 0);
        check_val("pre_rst_busy", 32'(bus.uart_cmd_busy), 32'd1);
        clear_seen();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        bus.uart_cmd_rx_data = 8'hA5;
        bus.uart_cmd_rx_rdy  = 1'b1;
        idle(2);
        check_val("rst_noerr", 32'(err_seen), 32'd0);
        check_val("rst_clr_held", 32'(bus.uart_cmd_rx_clr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_clr", 32'(bus.uart_cmd_rx_clr), 32'd1);
        check_val("post_rst_busy", 32'(bus.uart_cmd_busy), 32'd1);
        bus.uart_cmd_rx_rdy = 1'b0;
        @(negedge clk);
        check_val("post_rst_fall", 32'(bus.uart_cmd_rx_clr), 32'd0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        idle(3);
        check_val("post_rst_start", 32'(start_seen), 32'd1);
        check_val("post_rst_noerr", 32'(err_seen), 32'd0);

        // Error counter saturation over 300 bad frames
        clear_seen();
        for (int i = 0; i < 255; i++) begin
            send_byte(8'hA5, 0);
            send_byte(8'h07, 0);
        end
        idle(2);
        check_val("sat_255", 32'(bus.uart_cmd_err_cnt), 32'd255);
        for (int i = 0; i < 45; i++) begin
            send_byte(8'hA5, 0);
            send_byte(8'h07, 0);
        end
        idle(2);
        check_val("sat_hold", 32'(bus.uart_cmd_err_cnt), 32'd255);
        check_val("sat_pulses", 32'(err_seen), 32'd300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
